ahp_top: RTL and testbench

Self-contained AHB-Lite subsystem: one built-in traffic-generating master, an address decoder/response mux, and two 256-entry slave memories. After reset the master copies every valid entry of slave 1 into slave 2, one word at a time. The top is the system root; no bus signals leave the block, and all checking is by hierarchical access to the slave memories and the master status.

---
 rtl/ahp_master_pkg.sv | 41 ++++
 rtl/ahp_master.sv | 107 ++++++++++
 rtl/ahp_slave.sv | 97 +++++++++
 rtl/ahp_top.sv | 111 +++++++++++
 tb/tb_ahp_top.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahp_master_pkg.sv
// AHB-Lite copy subsystem: shared bus encodings,
// fixed geometry and master state enum.
package AHP_MASTER_PKG;

  localparam int MEM_DEPTH = 256;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 9;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_DONE
  } mst_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_S1,
    SEL_S2
  } sel_e;

  function automatic logic htrans_active(
    input logic [1:0] t
  );
    return (t == HTRANS_NONSEQ) ||
           (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahp_master.sv
// Copy master: reads slave_1 entry i, writes it
// to slave_2 entry i, skipping ERROR reads.
module ahp_master
  import AHP_MASTER_PKG::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [7:0] HRDATA_i,
  input  logic       HREADY_i,
  input  logic       HRESP_i,
  output logic [1:0] HTRANS_o,
  output logic [8:0] HADDR_o,
  output logic       HWRITE_o,
  output logic [2:0] HSIZE_o,
  output logic [7:0] HWDATA_o,
  output logic       done_o
);

  mst_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic       wait_q, wait_d;
  logic [7:0] data_q, data_d;
  logic       last;

  assign last = (idx_q == 8'hFF);

  // State register
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q <= ST_RST_WAIT;
      idx_q   <= '0;
      wait_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; index stops at 255 instead of wrapping
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    data_d  = data_q;
    unique case (state_q)
      ST_RST_WAIT: begin
        wait_d = 1'b1;
        if (wait_q) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (HREADY_i) begin
          data_d = HRDATA_i;
          if (HRESP_i == HRESP_OKAY) begin
            state_d = ST_WR_ADDR;
          end else if (last) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_WR_ADDR: state_d = ST_WR_DATA;
      ST_WR_DATA: begin
        if (HREADY_i) begin
          if (last) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RST_WAIT;
    endcase
  end

  // Bus outputs decoded from state; IDLE and zero elsewhere
  always_comb begin
    HTRANS_o = HTRANS_IDLE;
    HADDR_o  = '0;
    HWRITE_o = 1'b0;
    HSIZE_o  = HSIZE_BYTE;
    HWDATA_o = '0;
    done_o   = 1'b0;
    unique case (state_q)
      ST_RD_ADDR: begin
        HTRANS_o = HTRANS_NONSEQ;
        HADDR_o  = {1'b0, idx_q};
      end
      ST_WR_ADDR: begin
        HTRANS_o = HTRANS_NONSEQ;
        HADDR_o  = {1'b1, idx_q};
        HWRITE_o = 1'b1;
      end
      ST_WR_DATA: HWDATA_o = data_q;
      ST_DONE:    done_o   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ahp_slave.sv
// AHB-Lite slave memory: 256 x {valid, byte}.
// Invalid reads return a two-cycle ERROR.
module ahp_slave
  import AHP_MASTER_PKG::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSEL_i,
  input  logic [7:0] HADDR_i,
  input  logic [1:0] HTRANS_i,
  input  logic       HWRITE_i,
  input  logic [2:0] HSIZE_i,
  input  logic [7:0] HWDATA_i,
  input  logic       HREADY_i,
  output logic       HREADYOUT_o,
  output logic       HRESP_o,
  output logic [7:0] HRDATA_o
);

  logic [8:0] SLAVE_MEM [0:MEM_DEPTH-1];

  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       err1_q, err1_d;
  logic       err2_q, err2_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rdata_q, rdata_d;

  logic       accept;
  logic [8:0] entry;

  assign accept = HSEL_i && HREADY_i &&
                  htrans_active(HTRANS_i) &&
                  (HSIZE_i == HSIZE_BYTE);
  assign entry  = SLAVE_MEM[HADDR_i];

  // Next data-phase state from the current address phase
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    err1_d  = err1_q;
    err2_d  = err2_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    if (err1_q) begin
      err1_d = 1'b0;
      err2_d = 1'b1;
    end else if (HREADY_i) begin
      rd_d   = 1'b0;
      wr_d   = 1'b0;
      err2_d = 1'b0;
      if (accept) begin
        addr_d = HADDR_i;
        if (HWRITE_i) begin
          wr_d = 1'b1;
        end else if (entry[8]) begin
          rd_d    = 1'b1;
          rdata_d = entry[7:0];
        end else begin
          err1_d = 1'b1;
        end
      end
    end
  end

  // Data-phase control registers
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err1_q  <= 1'b0;
      err2_q  <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err1_q  <= err1_d;
      err2_q  <= err2_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Commit write at the edge ending its data phase; never cleared by reset
  always_ff @(posedge HCLK) begin
    if (wr_q && HREADY_i) begin
      SLAVE_MEM[addr_q] <= {1'b1, HWDATA_i};
    end
  end

  assign HREADYOUT_o = ~err1_q;
  assign HRESP_o     = (err1_q || err2_q) ?
                       HRESP_ERROR : HRESP_OKAY;
  assign HRDATA_o    = rd_q ? rdata_q : 8'h00;

endmodule

// File: rtl/ahp_top.sv
// System root: copy master, HADDR[8] decoder,
// response mux and two slave memories.
module ahp_top
  import AHP_MASTER_PKG::*;
(
  input logic HCLK,
  input logic HRESETn
);

  logic [1:0] htrans;
  logic [8:0] haddr;
  logic       hwrite;
  logic [2:0] hsize;
  logic [7:0] hwdata;
  logic [7:0] hrdata;
  logic       hready;
  logic       hresp;
  logic       done;

  logic       s1_sel, s2_sel;
  logic       s1_ready, s2_ready;
  logic       s1_resp, s2_resp;
  logic [7:0] s1_rdata, s2_rdata;

  sel_e sel_q, sel_d;

  ahp_master u_master (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HRDATA_i (hrdata),
    .HREADY_i (hready),
    .HRESP_i  (hresp),
    .HTRANS_o (htrans),
    .HADDR_o  (haddr),
    .HWRITE_o (hwrite),
    .HSIZE_o  (hsize),
    .HWDATA_o (hwdata),
    .done_o   (done)
  );

  assign s1_sel = ~haddr[8];
  assign s2_sel =  haddr[8];

  ahp_slave slave_1 (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL_i      (s1_sel),
    .HADDR_i     (haddr[7:0]),
    .HTRANS_i    (htrans),
    .HWRITE_i    (hwrite),
    .HSIZE_i     (hsize),
    .HWDATA_i    (hwdata),
    .HREADY_i    (hready),
    .HREADYOUT_o (s1_ready),
    .HRESP_o     (s1_resp),
    .HRDATA_o    (s1_rdata)
  );

  ahp_slave slave_2 (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL_i      (s2_sel),
    .HADDR_i     (haddr[7:0]),
    .HTRANS_i    (htrans),
    .HWRITE_i    (hwrite),
    .HSIZE_i     (hsize),
    .HWDATA_i    (hwdata),
    .HREADY_i    (hready),
    .HREADYOUT_o (s2_ready),
    .HRESP_o     (s2_resp),
    .HRDATA_o    (s2_rdata)
  );

  // Data-phase owner for the next cycle
  always_comb begin
    sel_d = SEL_NONE;
    if (htrans_active(htrans)) begin
      sel_d = haddr[8] ? SEL_S2 : SEL_S1;
    end
  end

  // Select advances only when the current data phase completes
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      sel_q <= SEL_NONE;
    end else if (hready) begin
      sel_q <= sel_d;
    end
  end

  // Response mux; no owner means zero-wait OKAY
  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    unique case (sel_q)
      SEL_S1: begin
        hready = s1_ready;
        hresp  = s1_resp;
        hrdata = s1_rdata;
      end
      SEL_S2: begin
        hready = s2_ready;
        hresp  = s2_resp;
        hrdata = s2_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahp_top.sv
// Bench for ahp_top: bus monitor feeds observed
// writes; each test compares against its expectations.
module tb_ahp_top;
  import AHP_MASTER_PKG::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ahp_top dut (
    .HCLK    (clk),
    .HRESETn (rst)
  );

  wire [1:0] htrans = dut.htrans;
  wire [8:0] haddr  = dut.haddr;
  wire       hwrite = dut.hwrite;
  wire [7:0] hwdata = dut.hwdata;
  wire       hready = dut.hready;
  wire       hresp  = dut.hresp;
  wire       done   = dut.done;

  logic [16:0] exp_q [$];
  logic [16:0] obs_q [$];
  logic [8:0]  err_q [$];
  int          err2_cnt = 0;
  int          bad_dec  = 0;

  logic        ph_wr = 1'b0;
  logic        ph_rd = 1'b0;
  logic [8:0]  ph_addr = '0;
  logic        commit_nx = 1'b0;
  logic [16:0] commit_val = '0;
  logic [8:0]  snap [0:255];

  // Monitor: follow address/data phases between edges
  always @(negedge clk) begin
    commit_nx = 1'b0;
    if (rst) begin
      ph_wr = 1'b0;
      ph_rd = 1'b0;
    end else begin
      if (ph_rd && hresp && !hready) err_q.push_back(ph_addr);
      if (ph_rd && hresp && hready) err2_cnt++;
      if (ph_wr && hready) begin
        commit_nx  = 1'b1;
        commit_val = {ph_addr, hwdata};
      end
      if (hready) begin
        ph_wr   = (htrans == 2'd2) && hwrite;
        ph_rd   = (htrans == 2'd2) && !hwrite;
        ph_addr = haddr;
        if (htrans == 2'd2 && hwrite != haddr[8]) bad_dec++;
      end
    end
  end

  always @(posedge clk) begin
    if (commit_nx && !rst) obs_q.push_back(commit_val);
  end

  task automatic load_mem(input logic [7:0] xr,
                          input logic [7:0] s2v);
    for (int i = 0; i < 256; i++) begin
      dut.slave_1.SLAVE_MEM[i] = {1'b1, 8'(i) ^ xr};
      dut.slave_2.SLAVE_MEM[i] = {1'b1, s2v};
    end
  endtask

  task automatic push_all(input logic [7:0] xr,
                          input int skip);
    for (int i = 0; i < 256; i++) begin
      if (i != skip) exp_q.push_back({1'b1, 8'(i), 8'(i) ^ xr});
    end
  endtask

  task automatic enter_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    err_q.delete();
    err2_cnt = 0;
    bad_dec  = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain_scoreboard(input string tag);
    logic [16:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 17'h1FFFF;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s write: got %h want %h", tag, o, e);
      end
    end
    tests_run++;
    if (obs_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL %s extra writes: got %0d want 0",
               tag, obs_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if ({htrans, haddr, hwdata, done, hready, hresp} !==
          {2'd0, 9'd0, 8'd0, 1'b0, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset c%0d: tr=%h a=%h d=%h dn=%b rdy=%b rsp=%b",
                 c, htrans, haddr, hwdata, done, hready, hresp);
      end
    end
  endtask

  task automatic test_all_valid();
    int n, bad;
    enter_reset();
    load_mem(8'hA5, 8'h00);
    push_all(8'hA5, -1);
    rst = 1'b0;
    wait_done(n);
    tests_run++;
    if (n !== 1026) begin
      tests_failed++;
      $display("FAIL all_valid cycles: got %0d want 1026", n);
    end
    drain_scoreboard("all_valid");
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut.slave_2.SLAVE_MEM[i] !== {1'b1, 8'(i) ^ 8'hA5}) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL all_valid mem: got %0d bad want 0", bad);
    end
  endtask

  task automatic test_invalid_entry();
    int n;
    enter_reset();
    load_mem(8'hA5, 8'h00);
    dut.slave_1.SLAVE_MEM[7] = 9'h0A2;
    dut.slave_2.SLAVE_MEM[7] = 9'h13C;
    push_all(8'hA5, 7);
    rst = 1'b0;
    wait_done(n);
    tests_run++;
    if (n !== 1025) begin
      tests_failed++;
      $display("FAIL invalid cycles: got %0d want 1025", n);
    end
    tests_run++;
    if (err_q.size() !== 1 || err2_cnt !== 1 ||
        (err_q.size() > 0 && err_q[0] !== 9'h007)) begin
      tests_failed++;
      $display("FAIL invalid err: got n=%0d e2=%0d want 1 1 at 007",
               err_q.size(), err2_cnt);
    end
    drain_scoreboard("invalid");
    tests_run++;
    if (dut.slave_2.SLAVE_MEM[7] !== 9'h13C) begin
      tests_failed++;
      $display("FAIL invalid keep7: got %h want 13C",
               dut.slave_2.SLAVE_MEM[7]);
    end
    tests_run++;
    if (dut.slave_2.SLAVE_MEM[8] !== 9'h1AD) begin
      tests_failed++;
      $display("FAIL invalid copy8: got %h want 1AD",
               dut.slave_2.SLAVE_MEM[8]);
    end
  endtask

  task automatic test_boundary();
    int n, busy;
    enter_reset();
    load_mem(8'hA5, 8'h00);
    dut.slave_1.SLAVE_MEM[255] = 9'h1FF;
    for (int i = 0; i < 255; i++)
      exp_q.push_back({1'b1, 8'(i), 8'(i) ^ 8'hA5});
    exp_q.push_back({9'h1FF, 8'hFF});
    rst = 1'b0;
    wait_done(n);
    tests_run++;
    if (n !== 1026) begin
      tests_failed++;
      $display("FAIL boundary cycles: got %0d want 1026", n);
    end
    drain_scoreboard("boundary");
    tests_run++;
    if (dut.slave_2.SLAVE_MEM[255] !== 9'h1FF) begin
      tests_failed++;
      $display("FAIL boundary m255: got %h want 1FF",
               dut.slave_2.SLAVE_MEM[255]);
    end
    busy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (htrans !== 2'd0 || done !== 1'b1) busy++;
    end
    tests_run++;
    if (busy !== 0 || obs_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL boundary idle: got busy=%0d wr=%0d want 0 0",
               busy, obs_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int n, bad;
    enter_reset();
    load_mem(8'h5A, 8'h00);
    for (int i = 0; i < 100; i++)
      exp_q.push_back({1'b1, 8'(i), 8'(i) ^ 8'h5A});
    rst = 1'b0;
    n = 0;
    while (!(dut.u_master.state_q == ST_WR_ADDR &&
             dut.u_master.idx_q == 8'd100) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 2000) begin
      tests_failed++;
      $display("FAIL midrun reach: got timeout want WR_ADDR i=100");
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (htrans !== 2'd0 || haddr !== 9'd0) begin
      tests_failed++;
      $display("FAIL midrun idle: got tr=%h a=%h want 0 0",
               htrans, haddr);
    end
    repeat (2) @(negedge clk);
    drain_scoreboard("midrun_pass1");
    tests_run++;
    if (dut.slave_2.SLAVE_MEM[100] !== 9'h100) begin
      tests_failed++;
      $display("FAIL midrun m100: got %h want 100",
               dut.slave_2.SLAVE_MEM[100]);
    end
    push_all(8'h5A, -1);
    rst = 1'b0;
    wait_done(n);
    tests_run++;
    if (n !== 1026) begin
      tests_failed++;
      $display("FAIL midrun cycles: got %0d want 1026", n);
    end
    drain_scoreboard("midrun_pass2");
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut.slave_2.SLAVE_MEM[i] !== {1'b1, 8'(i) ^ 8'h5A}) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL midrun mem: got %0d bad want 0", bad);
    end
  endtask

  task automatic test_decode();
    int n, bad;
    enter_reset();
    load_mem(8'h3C, 8'h11);
    for (int i = 0; i < 256; i++) snap[i] = {1'b1, 8'(i) ^ 8'h3C};
    push_all(8'h3C, -1);
    rst = 1'b0;
    wait_done(n);
    tests_run++;
    if (bad_dec !== 0) begin
      tests_failed++;
      $display("FAIL decode dir: got %0d bad want 0", bad_dec);
    end
    drain_scoreboard("decode");
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut.slave_1.SLAVE_MEM[i] !== snap[i]) bad++;
      if (dut.slave_2.SLAVE_MEM[i] !== snap[i]) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL decode mem: got %0d bad want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_invalid_entry();
    test_boundary();
    test_reset_mid_run();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
